// File: rtl/delay_sequencer.sv
// delay_sequencer
//
// Run-time controller for a programmable delay line (memory write pointer plus
// delayed read). It owns the delay-line control lines, resets the line whenever
// a new delay is accepted, then counts sample strobes until the delayed output
// holds real data. Until then, the sample is masked to zero and reported invalid.
//
// Handshake: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both high. o_req_ready depends only on the state and on
// i_reset, never on i_req_valid. If a request asks for the delay already in
// force, it is consumed but has no effect.
//
// Ports
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_ce              sample strobe from upstream
//   i_req_valid       new-delay request valid
//   o_req_ready       request can be accepted this cycle
//   i_req_delay       requested delay, in samples
//   o_dly_delay       delay currently driven to the delay line
//   o_dly_reset       one-cycle registered reset pulse to the delay line
//   o_dly_ce          strobe to the delay line (i_ce passed through)
//   i_dly_delayed     delayed sample returned by the delay line
//   o_sample          i_dly_delayed when valid, else zero
//   o_sample_valid    delayed output is valid
//   o_busy            high whenever not in RUN
//   o_nchanges        applied-change counter (see macro below)
//   o_state           FSM state, for debug and checkers
//
// Optional build macro DELAY_SEQ_STATS_EN:
//   When defined, o_nchanges is a saturating count of request-driven APPLY
//   entries. It is cleared by reset. When undefined, o_nchanges is tied to zero.

module delay_sequencer #(
    parameter int                 LGDLY      = 4,
    parameter int                 DW         = 12,
    parameter logic [LGDLY-1:0]   INIT_DELAY = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ce,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [LGDLY-1:0]  i_req_delay,
    output logic [LGDLY-1:0]  o_dly_delay,
    output logic              o_dly_reset,
    output logic              o_dly_ce,
    input  logic [DW-1:0]     i_dly_delayed,
    output logic [DW-1:0]     o_sample,
    output logic              o_sample_valid,
    output logic              o_busy,
    output logic [7:0]        o_nchanges,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        APPLY = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LGDLY:0]     count, count_nxt;   // one extra bit: max load is 2^LGDLY
    logic [LGDLY-1:0]   delay_q, delay_nxt;
    logic               dly_reset_q, dly_reset_nxt;
    logic               accept;
    logic               change;

    assign o_req_ready = (state != APPLY) && !i_reset;
    assign accept      = i_req_valid && o_req_ready;
    // A request for the delay already in force is consumed without effect.
    assign change      = accept && (i_req_delay != delay_q);

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        delay_nxt     = delay_q;
        dly_reset_nxt = 1'b0;
        case (state)
            APPLY: begin
                // Strobes during APPLY reach the line but are not counted.
                state_nxt = FLUSH;
                count_nxt = {1'b0, delay_q} + {{LGDLY{1'b0}}, 1'b1};
            end
            FLUSH: begin
                if (change) begin
                    state_nxt     = APPLY;
                    delay_nxt     = i_req_delay;
                    dly_reset_nxt = 1'b1;
                end else if (i_ce) begin
                    if (count == {{LGDLY{1'b0}}, 1'b1}) begin
                        state_nxt = RUN;
                    end else begin
                        count_nxt = count - {{LGDLY{1'b0}}, 1'b1};
                    end
                end
            end
            RUN: begin
                if (change) begin
                    state_nxt     = APPLY;
                    delay_nxt     = i_req_delay;
                    dly_reset_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt     = APPLY;
                dly_reset_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= APPLY;
            count       <= '0;
            delay_q     <= INIT_DELAY;
            dly_reset_q <= 1'b1;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            delay_q     <= delay_nxt;
            dly_reset_q <= dly_reset_nxt;
        end
    end

    assign o_dly_delay    = delay_q;
    assign o_dly_reset    = dly_reset_q;
    assign o_dly_ce       = i_ce;
    assign o_sample_valid = (state == RUN);
    assign o_busy         = (state != RUN);
    assign o_sample       = o_sample_valid ? i_dly_delayed : '0;
    assign o_state        = state;

`ifdef DELAY_SEQ_STATS_EN
    logic [7:0] nchanges;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            nchanges <= '0;
        end else if (change && (nchanges != 8'hFF)) begin
            nchanges <= nchanges + 8'd1;
        end
    end

    assign o_nchanges = nchanges;
`else
    assign o_nchanges = 8'd0;
`endif

endmodule
